// File: rtl/gf180_sram_wb_ctrl_pkg.sv
// rtl/gf180_sram_wb_ctrl_pkg.sv - shared FSM encodings and SRAM pin idle levels
package gf180_sram_wb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  localparam logic       CEN_IDLE  = 1'b1;
  localparam logic       GWEN_IDLE = 1'b1;
  localparam logic [7:0] WEN_NONE  = 8'hFF;
  localparam logic [7:0] WEN_ALL   = 8'h00;

endpackage

// File: rtl/gf180_sram_wb_ctrl.sv
// rtl/gf180_sram_wb_ctrl.sv - Wishbone classic slave sequencing a gf180 512x8 SRAM macro
// One bus word becomes LANES byte cycles on the macro; all pins and bus outputs are registered.
module gf180_sram_wb_ctrl
  import gf180_sram_wb_ctrl_pkg::*;
#(
  parameter int SRAM_AW = 9,
  parameter int LANES   = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [LANES-1:0]     wb_sel_i,
  input  logic [SRAM_AW-1:0]   wb_adr_i,
  input  logic [8*LANES-1:0]   wb_dat_i,
  output logic [8*LANES-1:0]   wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 sram_cen,
  output logic                 sram_gwen,
  output logic [7:0]           sram_wen,
  output logic [SRAM_AW-1:0]   sram_a,
  output logic [7:0]           sram_d,
  input  logic [7:0]           sram_q
);

  localparam int BW  = $clog2(LANES);
  localparam int WAW = SRAM_AW - BW;
  localparam logic [BW-1:0] BEAT_LAST = BW'(LANES - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

  state_t              state, state_n;
  logic [BW-1:0]       beat, beat_n;
  logic                we_q;
  logic [LANES-1:0]    sel_q;
  logic [WAW-1:0]      word_q;
  logic [8*LANES-1:0]  dat_q;

  logic                latch, issue, issue_we, ack_n;
  logic [BW-1:0]       issue_beat;
  logic [LANES-1:0]    issue_sel;
  logic [WAW-1:0]      issue_word;
  logic [8*LANES-1:0]  issue_dat;

  logic                cen_n, gwen_n;
  logic [7:0]          wen_n, d_n;
  logic [SRAM_AW-1:0]  a_n;

  logic                rd_q, cap_vld;
  logic [BW-1:0]       rd_beat_q, cap_lane;

  logic                adr_lsb_unused;
  assign adr_lsb_unused = ^wb_adr_i[BW-1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      beat  <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
    end
  end

  // issue_* describes the beat whose pins get registered at this edge
  always_comb begin
    state_n    = state;
    beat_n     = beat;
    ack_n      = 1'b0;
    latch      = 1'b0;
    issue      = 1'b0;
    issue_beat = beat;
    issue_we   = we_q;
    issue_sel  = sel_q;
    issue_word = word_q;
    issue_dat  = dat_q;
    unique case (state)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          latch      = 1'b1;
          state_n    = ST_ACCESS;
          beat_n     = '0;
          issue      = 1'b1;
          issue_beat = '0;
          issue_we   = wb_we_i;
          issue_sel  = wb_sel_i;
          issue_word = wb_adr_i[SRAM_AW-1:BW];
          issue_dat  = wb_dat_i;
        end
      end
      ST_ACCESS: begin
        if (!wb_cyc_i) begin
          state_n = ST_IDLE;
          beat_n  = '0;
        end else if (beat == BEAT_LAST) begin
          state_n = we_q ? ST_ACK : ST_DRAIN;
          ack_n   = we_q;
          beat_n  = '0;
        end else begin
          beat_n     = beat + BEAT_ONE;
          issue      = 1'b1;
          issue_beat = beat + BEAT_ONE;
        end
      end
      ST_DRAIN: begin
        if (!wb_cyc_i) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_ACK;
          ack_n   = 1'b1;
        end
      end
      ST_ACK:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // address/data hold their last value while idle to avoid needless pin toggling
  always_comb begin
    cen_n  = CEN_IDLE;
    gwen_n = GWEN_IDLE;
    wen_n  = WEN_NONE;
    a_n    = sram_a;
    d_n    = sram_d;
    if (issue) begin
      a_n = {issue_word, issue_beat};
      if (!issue_we) begin
        cen_n = 1'b0;
      end else if (issue_sel[issue_beat]) begin
        cen_n  = 1'b0;
        gwen_n = 1'b0;
        wen_n  = WEN_ALL;
        d_n    = issue_dat[8*issue_beat +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q      <= 1'b0;
      sel_q     <= '0;
      word_q    <= '0;
      dat_q     <= '0;
      sram_cen  <= CEN_IDLE;
      sram_gwen <= GWEN_IDLE;
      sram_wen  <= WEN_NONE;
      sram_a    <= '0;
      sram_d    <= '0;
      rd_q      <= 1'b0;
      rd_beat_q <= '0;
      cap_vld   <= 1'b0;
      cap_lane  <= '0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
    end else begin
      if (latch) begin
        we_q   <= wb_we_i;
        sel_q  <= wb_sel_i;
        word_q <= wb_adr_i[SRAM_AW-1:BW];
        dat_q  <= wb_dat_i;
      end
      sram_cen  <= cen_n;
      sram_gwen <= gwen_n;
      sram_wen  <= wen_n;
      sram_a    <= a_n;
      sram_d    <= d_n;
      // rd_q tracks a read beat on the pins; macro data appears one cycle later
      rd_q      <= issue & ~issue_we;
      rd_beat_q <= issue_beat;
      cap_vld   <= rd_q;
      cap_lane  <= rd_beat_q;
      if (cap_vld) wb_dat_o[8*cap_lane +: 8] <= sram_q;
      wb_ack_o  <= ack_n;
    end
  end

endmodule

// File: tb/tb_gf180_sram_wb_ctrl.sv
// tb/tb_gf180_sram_wb_ctrl.sv - directed and random checks of gf180_sram_wb_ctrl against a byte scoreboard
module tb_gf180_sram_wb_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [8:0]  wb_adr_i = 9'h0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        sram_cen, sram_gwen;
  logic [7:0]  sram_wen, sram_d, sram_q;
  logic [8:0]  sram_a;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  gf180_sram_wb_ctrl #(.SRAM_AW(9), .LANES(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  // behavioural 512x8 macro: pins sampled at the edge, q valid the following cycle
  logic [7:0] mem [0:511];
  logic       init_req = 1'b0, poke_en = 1'b0;
  logic [8:0] poke_a = 9'h0;
  logic [7:0] poke_d = 8'h0;

  always @(posedge CLK) begin
    if (init_req) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'((i * 7 + 3) ^ (i >> 3));
    end else if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (!sram_cen) begin
      if (!sram_gwen) begin
        for (int b = 0; b < 8; b++) if (!sram_wen[b]) mem[sram_a][b] <= sram_d[b];
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  // pin and ack activity, written only here
  int         ack_cnt = 0, act_cnt = 0, word_err = 0;
  int         act_hits [0:511];
  logic [6:0] exp_word = 7'h0;

  initial for (int i = 0; i < 512; i++) act_hits[i] = 0;

  always @(negedge CLK) begin
    if (wb_ack_o) ack_cnt++;
    if (!sram_cen) begin
      act_cnt++;
      act_hits[sram_a]++;
      if (sram_a[8:2] != exp_word) word_err++;
    end
  end

  logic [7:0] sb [0:511];

  task automatic step();
    @(posedge CLK); #1;
  endtask

  function automatic logic [31:0] sb_word(input logic [8:0] adr);
    logic [8:0] w;
    w = {adr[8:2], 2'b00};
    return {sb[w + 9'd3], sb[w + 9'd2], sb[w + 9'd1], sb[w]};
  endfunction

  task automatic sb_write(input logic [8:0] adr, input logic [31:0] d, input logic [3:0] sel);
    for (int k = 0; k < 4; k++) if (sel[k]) sb[{adr[8:2], 2'(k)}] = d[8*k +: 8];
  endtask

  task automatic poke(input logic [8:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    step();
    poke_en = 1'b0;
    sb[a] = d;
  endtask

  // drives one request, returns data and the ack cycle number (-1 on timeout)
  task automatic bus_xfer(input logic we, input logic [8:0] adr, input logic [31:0] wdat,
                          input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    exp_word = adr[8:2];
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = wdat; wb_sel_i = sel;
    lat = -1; rdat = 32'h0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (wb_ack_o) begin lat = n; rdat = wb_dat_o; break; end
    end
    if (lat > 0) step();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic test_reset();
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    for (int i = 0; i < 512; i++) sb[i] = 8'((i * 7 + 3) ^ (i >> 3));
    step();
    checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL rst_cen got %b want 1", sram_cen); end
    checks++; if (sram_gwen !== 1'b1) begin errors++; $display("FAIL rst_gwen got %b want 1", sram_gwen); end
    checks++; if (sram_wen !== 8'hFF) begin errors++; $display("FAIL rst_wen got %h want ff", sram_wen); end
    checks++; if (sram_a !== 9'h0) begin errors++; $display("FAIL rst_a got %h want 0", sram_a); end
    checks++; if (sram_d !== 8'h0) begin errors++; $display("FAIL rst_d got %h want 0", sram_d); end
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", wb_ack_o); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat got %h want 0", wb_dat_o); end
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] r; int lat;
    bus_xfer(1'b1, 9'h010, 32'h1234_5678, 4'hF, r, lat);
    sb_write(9'h010, 32'h1234_5678, 4'hF);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_wr_lat got %0d want 5", lat); end
    bus_xfer(1'b0, 9'h010, 32'h0, 4'h0, r, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL basic_rd_lat got %0d want 6", lat); end
    checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL basic_rd_dat got %h want 12345678", r); end
  endtask

  task automatic test_sel();
    logic [31:0] r; int lat, c0; int h0 [4];
    poke(9'h020, 8'hDD); poke(9'h021, 8'hCC); poke(9'h022, 8'hBB); poke(9'h023, 8'hAA);
    c0 = act_cnt;
    for (int k = 0; k < 4; k++) h0[k] = act_hits[9'h020 + 9'(k)];
    bus_xfer(1'b1, 9'h020, 32'h1122_3344, 4'b0101, r, lat);
    sb_write(9'h020, 32'h1122_3344, 4'b0101);
    checks++; if (act_cnt - c0 !== 2) begin errors++; $display("FAIL sel_active got %0d want 2", act_cnt - c0); end
    checks++;
    if (act_hits[9'h020] - h0[0] !== 1 || act_hits[9'h021] - h0[1] !== 0 ||
        act_hits[9'h022] - h0[2] !== 1 || act_hits[9'h023] - h0[3] !== 0) begin
      errors++;
      $display("FAIL sel_lanes got %0d%0d%0d%0d want 1010", act_hits[9'h020] - h0[0],
               act_hits[9'h021] - h0[1], act_hits[9'h022] - h0[2], act_hits[9'h023] - h0[3]);
    end
    bus_xfer(1'b0, 9'h020, 32'h0, 4'h0, r, lat);
    checks++; if (r !== 32'hAA22_CC44) begin errors++; $display("FAIL sel_rd_dat got %h want aa22cc44", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat, e0; int h0 [4];
    e0 = word_err;
    for (int k = 0; k < 4; k++) h0[k] = act_hits[9'h1FC + 9'(k)];
    bus_xfer(1'b1, 9'h1FC, 32'hDEAD_BEEF, 4'hF, r, lat);
    sb_write(9'h1FC, 32'hDEAD_BEEF, 4'hF);
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_wr_lat got %0d want 5", lat); end
    bus_xfer(1'b0, 9'h1FF, 32'h0, 4'h0, r, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_rd_lat got %0d want 6", lat); end
    checks++; if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_rd_dat got %h want deadbeef", r); end
    checks++; if (word_err !== e0) begin errors++; $display("FAIL b2b_wrap got %0d stray beats want 0", word_err - e0); end
    checks++;
    if (act_hits[9'h1FC] - h0[0] !== 2 || act_hits[9'h1FF] - h0[3] !== 2) begin
      errors++;
      $display("FAIL b2b_top_hits got %0d/%0d want 2/2", act_hits[9'h1FC] - h0[0], act_hits[9'h1FF] - h0[3]);
    end
    bus_xfer(1'b0, 9'h000, 32'h0, 4'h0, r, lat);
    checks++; if (r !== sb_word(9'h000)) begin errors++; $display("FAIL b2b_word0 got %h want %h", r, sb_word(9'h000)); end
  endtask

  task automatic test_abort();
    logic [31:0] r, old; int lat, a0; logic found;
    old = sb_word(9'h040);
    a0 = ack_cnt;
    exp_word = 7'h10;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 9'h040; wb_dat_i = 32'h5566_7788; wb_sel_i = 4'hF;
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (!sram_cen && sram_a == 9'h041) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL abort_beat1 got none want a=041"); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    step();
    checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL abort_pins got cen=%b want 1", sram_cen); end
    repeat (4) step();
    checks++; if (ack_cnt !== a0) begin errors++; $display("FAIL abort_noack got %0d acks want 0", ack_cnt - a0); end
    sb[9'h040] = 8'h88; sb[9'h041] = 8'h77;
    bus_xfer(1'b0, 9'h040, 32'h0, 4'h0, r, lat);
    checks++;
    if (r !== {old[31:16], 16'h7788}) begin
      errors++; $display("FAIL abort_rd_dat got %h want %h", r, {old[31:16], 16'h7788});
    end
  endtask

  task automatic test_stb_drop();
    logic [31:0] r; int lat;
    exp_word = 7'h20;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 9'h080; wb_dat_i = 32'hCAFE_F00D; wb_sel_i = 4'hF;
    step();
    wb_stb_i = 1'b0;
    lat = -1;
    for (int n = 2; n <= 20; n++) begin
      step();
      if (wb_ack_o) begin lat = n; break; end
    end
    step();
    wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    sb_write(9'h080, 32'hCAFE_F00D, 4'hF);
    checks++; if (lat !== 5) begin errors++; $display("FAIL stb_drop_lat got %0d want 5", lat); end
    bus_xfer(1'b0, 9'h080, 32'h0, 4'h0, r, lat);
    checks++; if (r !== 32'hCAFE_F00D) begin errors++; $display("FAIL stb_drop_dat got %h want cafef00d", r); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] r; int lat, c0; logic found;
    exp_word = 7'h04;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 9'h010; wb_sel_i = 4'h0;
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (!sram_cen && sram_a[1:0] == 2'd2) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstmid_beat2 got none want beat 2"); end
    RST_N = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    #1;
    checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL rstmid_cen got %b want 1", sram_cen); end
    checks++; if (sram_wen !== 8'hFF) begin errors++; $display("FAIL rstmid_wen got %h want ff", sram_wen); end
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_ack got %b want 0", wb_ack_o); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL rstmid_dat got %h want 0", wb_dat_o); end
    c0 = act_cnt;
    repeat (3) step();
    checks++; if (act_cnt !== c0) begin errors++; $display("FAIL rstmid_quiet got %0d beats want 0", act_cnt - c0); end
    RST_N = 1'b1;
    step();
    bus_xfer(1'b0, 9'h010, 32'h0, 4'h0, r, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL rstmid_rd_lat got %0d want 6", lat); end
    checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL rstmid_rd_dat got %h want 12345678", r); end
  endtask

  task automatic test_random();
    logic [31:0] r, d, exp; logic [8:0] adr; logic [3:0] sel; logic we; int lat, a0, e0;
    e0 = word_err;
    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 3)) step();
      we  = 1'($urandom_range(0, 1));
      adr = 9'($urandom_range(0, 511));
      sel = 4'($urandom_range(0, 15));
      d   = $urandom;
      exp = sb_word(adr);
      a0  = ack_cnt;
      bus_xfer(we, adr, d, sel, r, lat);
      checks++;
      if (lat !== (we ? 5 : 6)) begin
        errors++; $display("FAIL rand_lat[%0d] got %0d want %0d", t, lat, we ? 5 : 6);
      end
      checks++;
      if (ack_cnt - a0 !== 1) begin errors++; $display("FAIL rand_acks[%0d] got %0d want 1", t, ack_cnt - a0); end
      if (we) begin
        sb_write(adr, d, sel);
      end else begin
        checks++;
        if (r !== exp) begin errors++; $display("FAIL rand_rd[%0d] adr %h got %h want %h", t, adr, r, exp); end
      end
    end
    checks++; if (word_err !== e0) begin errors++; $display("FAIL rand_wrap got %0d stray beats want 0", word_err - e0); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_sel();
    test_back_to_back();
    test_abort();
    test_stb_drop();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
